// File: rtl/elevator_call_ctrl_if.sv
// Elevator-side handshake between the call controller and the elevator FSM.
//   floor_req  : one-hot floor request from the controller (registered there)
//   move_up    : car is travelling up
//   move_down  : car is travelling down
//   door_open  : car door is open at the current floor
// master = call controller, slave = elevator FSM.
interface elevator_call_ctrl_if #(
  parameter int NUM_FLOORS = 4
);
  logic [NUM_FLOORS-1:0] floor_req;
  logic                  move_up;
  logic                  move_down;
  logic                  door_open;

  modport master (
    output floor_req,
    input  move_up,
    input  move_down,
    input  door_open
  );

  modport slave (
    input  floor_req,
    output move_up,
    output move_down,
    output door_open
  );
endinterface

// File: rtl/elevator_call_ctrl.sv
// Elevator call controller.
// Latches hall-call buttons, tracks the car position from the elevator's
// movement signals and issues one floor request at a time to the elevator
// FSM, waiting for the door to cycle before choosing the next call.
// Ports:
//   clk       : single clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset
//   btn       : level call buttons, bit i = floor i
//   bus       : elevator handshake (floor_req out; move_up/move_down/door_open in)
//   pending   : latched outstanding calls
//   cur_floor : tracked car position
//   busy      : controller is anywhere but IDLE
//   dir_err   : sticky flag, both movement directions seen together
module elevator_call_ctrl #(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_TICKS   = 16,
  parameter int REQ_HOLD      = 2,
  parameter int START_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] btn,
  elevator_call_ctrl_if.master  bus,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [1:0]            cur_floor,
  output logic                  busy,
  output logic                  dir_err
);

  localparam int TICK_W = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
  localparam int HOLD_W = (REQ_HOLD > 1) ? $clog2(REQ_HOLD) : 1;
  localparam int WAIT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(FLOOR_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(REQ_HOLD - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(START_TIMEOUT - 1);
  localparam logic [1:0]        TOP_FLOOR = 2'(NUM_FLOORS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    WAIT_CLOSE
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_FLOORS-1:0] btn_prev_q;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [1:0]            cur_floor_q, cur_floor_d;
  logic                  last_dir_q, last_dir_d;
  logic                  dir_err_q, dir_err_d;
  logic [1:0]            target_q, target_d;
  logic                  sel_q, sel_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [NUM_FLOORS-1:0] floor_req_q, floor_req_d;

  logic                  elev_active;
  logic                  door_clear;
  logic [NUM_FLOORS-1:0] btn_rise;
  logic [NUM_FLOORS-1:0] clear_mask;

  // Sweep-preserving choice: keep going the way we last travelled
  // (current floor counts as "ahead"), otherwise turn around to the
  // nearest call behind.
  function automatic logic [1:0] pick_target(
    input logic [NUM_FLOORS-1:0] req,
    input logic [1:0]            here,
    input logic                  up_first
  );
    logic [1:0] best;
    logic       found;
    best  = 2'd0;
    found = 1'b0;
    if (up_first) begin
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
        if (req[i] && (i >= int'(here))) begin
          best  = 2'(i);
          found = 1'b1;
        end
      end
      if (!found) begin
        for (int i = 0; i < NUM_FLOORS; i++) begin
          if (req[i] && (i < int'(here))) best = 2'(i);
        end
      end
    end else begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (req[i] && (i <= int'(here))) begin
          best  = 2'(i);
          found = 1'b1;
        end
      end
      if (!found) begin
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
          if (req[i] && (i > int'(here))) best = 2'(i);
        end
      end
    end
    return best;
  endfunction

  assign elev_active = bus.move_up | bus.move_down | bus.door_open;

  // Calls are edge-captured so a held button cannot re-arm after service;
  // a new press in the same cycle as a door clear keeps the bit set.
  always_comb begin
    btn_rise   = btn & ~btn_prev_q;
    door_clear = bus.door_open && ((state_q == WAIT_DONE) || (state_q == WAIT_CLOSE));
    clear_mask = door_clear ? (NUM_FLOORS'(1) << cur_floor_q) : '0;
    pending_d  = (pending_q & ~clear_mask) | btn_rise;
  end

  // Dead-reckoning position: FLOOR_TICKS uninterrupted cycles in one
  // direction equal one floor. A reversal mid-count discards the partial
  // floor; a conflicting up+down freezes everything and flags the error.
  always_comb begin
    tick_d      = tick_q;
    cur_floor_d = cur_floor_q;
    last_dir_d  = last_dir_q;
    dir_err_d   = dir_err_q;
    if (bus.move_up && bus.move_down) begin
      dir_err_d = 1'b1;
    end else if (bus.move_up || bus.move_down) begin
      last_dir_d = bus.move_up;
      if ((tick_q != '0) && (bus.move_up != last_dir_q)) begin
        tick_d = '0;
      end else if (tick_q == TICK_MAX) begin
        tick_d = '0;
        if (bus.move_up) begin
          if (cur_floor_q != TOP_FLOOR) cur_floor_d = cur_floor_q + 2'd1;
        end else begin
          if (cur_floor_q != 2'd0) cur_floor_d = cur_floor_q - 2'd1;
        end
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end else begin
      tick_d = '0;
    end
  end

  // Next-state logic. IDLE takes two cycles to launch a request: one to
  // latch the target (sel), one to enter ISSUE.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sel_d    = 1'b0;
    hold_d   = hold_q;
    wait_d   = wait_q;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        wait_d = '0;
        if (sel_q) begin
          state_d = ISSUE;
        end else if ((pending_q != '0) && !elev_active) begin
          target_d = pick_target(pending_q, cur_floor_q, last_dir_q);
          sel_d    = 1'b1;
        end
      end
      ISSUE: begin
        if (hold_q == HOLD_MAX) begin
          hold_d  = '0;
          state_d = WAIT_START;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      WAIT_START: begin
        if (elev_active) begin
          wait_d  = '0;
          state_d = WAIT_DONE;
        end else if (wait_q == WAIT_MAX) begin
          wait_d  = '0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.door_open) state_d = WAIT_CLOSE;
      end
      WAIT_CLOSE: begin
        if (!bus.door_open) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. floor_req is registered from the next state so it is high
  // exactly while the FSM sits in ISSUE.
  always_comb begin
    busy        = (state_q != IDLE);
    floor_req_d = (state_d == ISSUE) ? (NUM_FLOORS'(1) << target_q) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      btn_prev_q  <= '0;
      pending_q   <= '0;
      tick_q      <= '0;
      cur_floor_q <= 2'd0;
      last_dir_q  <= 1'b1;
      dir_err_q   <= 1'b0;
      target_q    <= 2'd0;
      sel_q       <= 1'b0;
      hold_q      <= '0;
      wait_q      <= '0;
      floor_req_q <= '0;
    end else begin
      state_q     <= state_d;
      btn_prev_q  <= btn;
      pending_q   <= pending_d;
      tick_q      <= tick_d;
      cur_floor_q <= cur_floor_d;
      last_dir_q  <= last_dir_d;
      dir_err_q   <= dir_err_d;
      target_q    <= target_d;
      sel_q       <= sel_d;
      hold_q      <= hold_d;
      wait_q      <= wait_d;
      floor_req_q <= floor_req_d;
    end
  end

  assign bus.floor_req = floor_req_q;
  assign pending       = pending_q;
  assign cur_floor     = cur_floor_q;
  assign dir_err       = dir_err_q;

endmodule
